// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM states and frame-format constants.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through receive FIFO; head reads zero while empty.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on each pointer separates full (MSBs differ) from empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizer, clock glitch filter, frame FSM
// with inter-edge timeout, sticky error flags and a receive FIFO.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 10_000_000,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned FILTER_CYCLES = 8,
    parameter int unsigned TIMEOUT_US    = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam longint unsigned TO_CYCLES =
        longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam int unsigned TO_W   = $clog2(TO_CYCLES + 1);
    localparam int unsigned FILT_W = $clog2(FILTER_CYCLES + 1);

    logic [1:0]           clk_sync_q, data_sync_q;
    logic                 filt_q, filt_d;
    logic [FILT_W-1:0]    filt_cnt_q, filt_cnt_d;
    logic                 fall;
    ps2_state_e           state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 push, frame_ev, parity_ev, overflow_ev;
    logic                 fifo_empty, fifo_full;
    logic                 parity_err_q, frame_err_q, overflow_q;
    logic                 data_s;

    assign data_s = data_sync_q[1];

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_CYCLES - 1)) filt_d = clk_sync_q[1];
            else                                        filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    assign fall = filt_q && !filt_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = '0;
        push      = 1'b0;
        frame_ev  = 1'b0;
        parity_ev = 1'b0;
        if (state_q != IDLE && !fall) to_cnt_d = to_cnt_q + 1'b1;
        case (state_q)
            IDLE: if (fall) begin
                if (data_s == START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end else begin
                    frame_ev = 1'b1;
                end
            end
            DATA: if (fall) begin
                shift_d   = {data_s, shift_q[DATA_BITS-1:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
            end
            PARITY: if (fall) begin
                par_d   = data_s;
                state_d = STOP;
            end
            STOP: if (fall) begin
                state_d = IDLE;
                if (data_s != STOP_BIT)         frame_ev  = 1'b1;
                else if (!(^{shift_q, par_q}))  parity_ev = 1'b1;
                else                            push      = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !fall && to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
            state_d   = IDLE;
            frame_ev  = 1'b1;
            to_cnt_d  = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end
    end

    // A push into a full FIFO is only lost when no pop frees a slot this cycle.
    assign overflow_ev = push && fifo_full && !rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk};
            data_sync_q  <= {data_sync_q[0], ps2_data};
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            parity_err_q <= (parity_err_q && !clr_err) || parity_ev;
            frame_err_q  <= (frame_err_q && !clr_err) || frame_ev;
            overflow_q   <= (overflow_q && !clr_err) || overflow_ev;
        end
    end

    ps2_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_q),
        .pop       (rd_en),
        .head      (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rd_valid   = !fifo_empty;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: 1 MHz core clock, 10 kHz PS/2 device clock.
`timescale 1ns/1ps
module tb_ps2_rx;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int unsigned errors = 0;
    int unsigned checks = 0;

    ps2_rx #(
        .CLK_FREQ_HZ   (1_000_000),
        .FIFO_DEPTH    (4),
        .FILTER_CYCLES (8),
        .TIMEOUT_US    (1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #500 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 100 us PS/2 bit cell: data set mid-high, clock low for 50 us.
    task automatic send_bit(input logic b);
        ps2_data = b;
        #25_000;
        ps2_clk = 1'b0;
        #50_000;
        ps2_clk = 1'b1;
        #25_000;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        ps2_data = 1'b1;
        #20_000;
        @(negedge clk);
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic read_expect(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'h00);
        chk("rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        rst_n = 1'b1;
        #10_000;

        // Good frame 0x1C (three ones -> parity 0)
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("f1c_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        read_expect("f1c", 8'h1C);
        chk("f1c_empty_valid", 32'(rd_valid), 32'd0);
        chk("f1c_empty_data", 32'(rd_data), 32'h00);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("rd_empty_valid", 32'(rd_valid), 32'd0);

        // Bad parity
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("par_err", 32'(parity_err), 32'd1);
        chk("par_valid", 32'(rd_valid), 32'd0);
        chk("par_frame", 32'(frame_err), 32'd0);
        pulse_clr();
        chk("par_clr", 32'(parity_err), 32'd0);

        // Overflow: fifth byte dropped
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1);
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h04, 1'b0, 1'b1);
        chk("ovf_pre", 32'(overflow), 32'd0);
        send_frame(8'hF0, 1'b1, 1'b1);
        chk("ovf_set", 32'(overflow), 32'd1);
        read_expect("ovf_r0", 8'h01);
        read_expect("ovf_r1", 8'h02);
        read_expect("ovf_r2", 8'h03);
        read_expect("ovf_r3", 8'h04);
        @(negedge clk);
        chk("ovf_drained", 32'(rd_valid), 32'd0);
        pulse_clr();
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Truncated frame then 2 ms idle -> timeout
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2_000_000;
        @(negedge clk);
        chk("to_frame_err", 32'(frame_err), 32'd1);
        chk("to_state", 32'(dut.state_q), 32'(IDLE));
        chk("to_valid", 32'(rd_valid), 32'd0);
        pulse_clr();
        chk("to_clr", 32'(frame_err), 32'd0);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("to_next_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        read_expect("to_next", 8'h29);

        // Glitches in idle and mid-frame must not add bits
        glitch();
        #20_000;
        @(negedge clk);
        chk("gl_idle_state", 32'(dut.state_q), 32'(IDLE));
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        #10_000;
        glitch();
        #10_000;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        glitch();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        #20_000;
        @(negedge clk);
        chk("gl_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        read_expect("gl", 8'hF0);
        @(negedge clk);
        chk("gl_one_byte", 32'(rd_valid), 32'd0);

        // Reset mid-frame with a byte buffered
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("pre_rst_flag", 32'(parity_err), 32'd1);
        send_frame(8'h01, 1'b0, 1'b1);
        chk("pre_rst_valid", 32'(rd_valid), 32'd1);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #3_000;
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_data", 32'(rd_data), 32'h00);
        chk("mid_rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #10_000;
        @(negedge clk);
        chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("post_rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        read_expect("post_rst", 8'h5A);
        @(negedge clk);
        chk("post_rst_empty", 32'(rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 10_000_000: core clock frequency, used for the timeout count.
REQ-002 Parameter FIFO_DEPTH, default 4: receive FIFO entries; must be a power of two, 2 or more.
REQ-003 Parameter FILTER_CYCLES, default 8: consecutive equal samples required to accept a ps2_clk level change.
REQ-004 Parameter TIMEOUT_US, default 1000: longest idle gap between falling edges within a frame.
REQ-005 Port clk, input, 1 bit: core clock; the only clock in the block.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port ps2_clk, input, 1 bit: raw PS/2 clock from the device; asynchronous to clk.
REQ-008 Port ps2_data, input, 1 bit: raw PS/2 data from the device; asynchronous to clk.
REQ-009 Port rd_en, input, 1 bit: pop the FIFO head.
REQ-010 Port clr_err, input, 1 bit: clear all sticky error flags.
REQ-011 Port rd_data, output, 8 bits: FIFO head byte, first-word-fall-through.
REQ-012 Port rd_valid, output, 1 bit: FIFO not empty.
REQ-013 Ports parity_err, frame_err and overflow, outputs, 1 bit each: sticky error flags.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a two-flop synchronizer before any other use.
REQ-015 The filtered clock SHALL change level only after FILTER_CYCLES consecutive synchronized samples at the new level.
- Any shorter pulse is ignored.
REQ-016 A falling edge of the filtered clock SHALL be the only event that samples synchronized ps2_data.
REQ-017 The FSM SHALL have four states: IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: an edge with data 0 goes to DATA with bit count 0; an edge with data 1 sets frame_err and stays in IDLE.
REQ-019 DATA: 8 edges shift data in LSB first, then go to PARITY.
REQ-020 PARITY: one edge latches the parity bit, then go to STOP.
REQ-021 STOP, one edge, then always IDLE:
- stop bit 0: set frame_err, drop the byte;
- stop 1 but odd parity over data plus parity bit fails: set parity_err, drop;
- otherwise push the byte.
REQ-022 A pushed byte SHALL appear on rd_data with rd_valid=1 one clk cycle after the stop-bit edge is detected.
REQ-023 Outside IDLE, no falling edge for TIMEOUT_US*CLK_FREQ_HZ/1_000_000 cycles SHALL force IDLE, set frame_err and discard the partial byte.
- The timeout counter clears on every falling edge.
REQ-024 Push while full SHALL drop the byte and set overflow; the FIFO contents stay unchanged.
REQ-025 Push and rd_en in the same cycle while full SHALL both take effect, with no overflow.
REQ-026 rd_en while empty SHALL be ignored, with no pointer change.
REQ-027 rd_data SHALL be 8'h00 whenever rd_valid=0.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.
REQ-029 clr_err SHALL clear the flags the next cycle.
- If an error event occurs in the same cycle as clr_err, the flag reads 1.

Reset
REQ-030 rst_n low SHALL asynchronously force:
- FSM to IDLE;
- bit count, shift register and timeout counter to 0;
- FIFO empty: rd_valid=0, rd_data=8'h00;
- all error flags to 0;
- synchronizer and filtered-clock state to 1 (bus idle high).
REQ-031 Reset asserted mid-frame SHALL discard the partial frame.
- The first frame starting after release is received normally.

Structure
REQ-032 The FSM state enum and the frame constants (8 data bits, start=0, stop=1) SHALL live in the shared package ps2_pkg.
REQ-033 The FIFO SHALL be the sub-module ps2_rx_fifo, parameterized by FIFO_DEPTH.
- Ports: push, push_data, pop, head, empty, full.
REQ-034 The synchronizer, filter, FSM and timeout logic SHALL be in ps2_rx itself.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1, at a 10 kHz ps2_clk -> rd_valid=1, rd_data=8'h1C, no error flags; rd_en -> rd_valid=0.
REQ-036 Frame 0x1C with parity 1 -> parity_err=1 and rd_valid stays 0; clr_err -> parity_err=0.
REQ-037 Frames 0x01, 0x02, 0x03, 0x04, 0xF0 with no rd_en -> overflow=1; reads return 01, 02, 03, 04, then rd_valid=0.
REQ-038 Start bit plus 3 data bits, then ps2_clk held high 2 ms -> frame_err=1, FSM in IDLE; next frame 0x29 is received intact.
REQ-039 3-cycle low glitches on ps2_clk during idle and mid-frame -> no extra bits; frame 0xF0 (parity 1) is received correctly.
REQ-040 rst_n pulsed low after 5 data bits of a frame -> all outputs at reset values; next frame 0x5A is received correctly.
